// File: rtl/seg7_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan : time-multiplexed 4-digit 7-segment scanner (HH:MM) with      |
// |             per-slot deadtime blanking and a once-per-frame input shadow. |
// | Option    : SEG_LEADING_ZERO_BLANK_EN blanks slot 3 when hours tens = 0.  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module seg7_scan #(
   parameter int PRESCALE = 1024,
   parameter int DEADTIME = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] min0_i,
   input  logic [3:0] min1_i,
   input  logic [3:0] hour0_i,
   input  logic [3:0] hour1_i,
   input  logic       colon_i,
   output logic [6:0] seg_o,
   output logic       dp_o,
   output logic [3:0] an_o
);

   localparam int            c_cw   = 16;
   localparam logic [c_cw-1:0] c_last = c_cw'(PRESCALE - 1);
   localparam logic [c_cw-1:0] c_dead = c_cw'(DEADTIME);

   logic [c_cw-1:0] r_prescale;
   logic [1:0]      r_slot;
   logic [3:0][3:0] r_digits;     // [0]=min0 .. [3]=hour1
   logic            r_colon;

   logic            w_wrap;
   logic            w_blank;
   logic [3:0]      w_digit;
   logic [6:0]      w_dec;
   logic [6:0]      w_seg;
   logic [3:0]      w_an;
   logic            w_dp;

   assign w_wrap = (r_prescale == c_last);

   always_comb begin
      w_digit = r_digits[r_slot];
      case (w_digit)
         4'd0:    w_dec = 7'h3F;
         4'd1:    w_dec = 7'h06;
         4'd2:    w_dec = 7'h5B;
         4'd3:    w_dec = 7'h4F;
         4'd4:    w_dec = 7'h66;
         4'd5:    w_dec = 7'h6D;
         4'd6:    w_dec = 7'h7D;
         4'd7:    w_dec = 7'h07;
         4'd8:    w_dec = 7'h7F;
         4'd9:    w_dec = 7'h6F;
         default: w_dec = 7'h40;
      endcase

      w_blank = (r_prescale < c_dead);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if ((r_slot == 2'd3) && (r_digits[3] == 4'd0)) begin
         w_blank = 1'b1;
      end
`endif

      w_an  = w_blank ? 4'b0000 : (4'b0001 << r_slot);
      w_seg = w_blank ? 7'h00 : w_dec;
      w_dp  = !w_blank && (r_slot == 2'd2) && r_colon;
   end

   // Shadow loads on the last cycle of slot 3, so the new value takes effect
   // exactly at the start of the next frame's slot 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prescale <= '0;
         r_slot     <= 2'd0;
         r_digits   <= '0;
         r_colon    <= 1'b0;
         seg_o      <= 7'h00;
         dp_o       <= 1'b0;
         an_o       <= 4'b0000;
      end else begin
         if (w_wrap) begin
            r_prescale <= '0;
            r_slot     <= r_slot + 2'd1;
            if (r_slot == 2'd3) begin
               r_digits <= {hour1_i, hour0_i, min1_i, min0_i};
               r_colon  <= colon_i;
            end
         end else begin
            r_prescale <= r_prescale + 1'b1;
         end
         seg_o <= w_seg;
         dp_o  <= w_dp;
         an_o  <= w_an;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// Directed table-driven bench for seg7_scan with PRESCALE=8, DEADTIME=2.
module tb_seg7_scan;

   localparam int P = 8;
   localparam int D = 2;
   localparam int FRAME = 4 * P;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] min0, min1, hour0, hour1;
   logic       colon;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   seg7_scan #(.PRESCALE(P), .DEADTIME(D)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .min0_i  (min0),
      .min1_i  (min1),
      .hour0_i (hour0),
      .hour1_i (hour1),
      .colon_i (colon),
      .seg_o   (seg),
      .dp_o    (dp),
      .an_o    (an)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]      m0, m1, h0, h1;
      logic            col;
      logic [3:0][6:0] s;    // expected seg per slot, [0]=min0
      logic            dp;
   } vec_t;

   vec_t vecs[5];
   vec_t zv;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_vec(input vec_t v);
      min0  = v.m0;
      min1  = v.m1;
      hour0 = v.h0;
      hour1 = v.h1;
      colon = v.col;
   endtask

   task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es, input logic edp);
      tests++;
      if (an !== ea || seg !== es || dp !== edp) begin
         fails++;
         $display("FAIL %s cyc=%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                  name, cyc, an, seg, dp, ea, es, edp);
      end
   endtask

   // Expected output at position i (0..FRAME-1) of a frame displaying v.
   task automatic expect_pos(input string name, input int i, input vec_t v);
      int         slot;
      int         p;
      logic [3:0] ea;
      logic       blank;
      slot  = i / P;
      p     = i % P;
      blank = (p < D);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (slot == 3 && v.h1 == 4'd0) blank = 1'b1;
`endif
      if (blank) begin
         check(name, 4'b0000, 7'h00, 1'b0);
      end else begin
         ea = 4'b0001 << slot;
         check(name, ea, v.s[slot], (slot == 2) ? v.dp : 1'b0);
      end
   endtask

   // Advance to just after the next shadow-load edge.
   task automatic wait_load();
      step();
      while (cyc % FRAME != 0) step();
   endtask

   task automatic check_frame(input string name, input vec_t v);
      for (int i = 0; i < FRAME; i++) begin
         step();
         expect_pos(name, i, v);
      end
   endtask

   initial begin
      int cnt[4];
      logic [3:0] ea;
      vec_t v9;

      vecs[0] = '{4'd4, 4'd3, 4'd2, 4'd1, 1'b1, {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b1}; // 12:34
      vecs[1] = '{4'd7, 4'd0, 4'd5, 4'd0, 1'b0, {7'h3F, 7'h6D, 7'h3F, 7'h07}, 1'b0}; // 05:07
      vecs[2] = '{4'd6, 4'd5, 4'hA, 4'd1, 1'b1, {7'h06, 7'h40, 7'h6D, 7'h7D}, 1'b1}; // 1A:56
      vecs[3] = '{4'd6, 4'd7, 4'd8, 4'd9, 1'b0, {7'h6F, 7'h7F, 7'h07, 7'h7D}, 1'b0}; // 98:76
      vecs[4] = '{4'd0, 4'hC, 4'd1, 4'hF, 1'b1, {7'h40, 7'h06, 7'h40, 7'h3F}, 1'b1}; // F1:C0
      zv      = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0}; // 00:00

      rst_n = 1'b0;
      set_vec(vecs[0]);
      step();
      step();
      check("reset_state", 4'b0000, 7'h00, 1'b0);

      // Release between edges; first frame shows the reset shadow.
      #3 rst_n = 1'b1;
      cyc = 0;
      check_frame("first_frame_zero", zv);
      check_frame("frame_12_34", vecs[0]);

      for (int k = 1; k < 5; k++) begin
         set_vec(vecs[k]);
         wait_load();
         check_frame($sformatf("vec%0d", k), vecs[k]);
      end

      // Input change mid-frame must not reach the display until next frame.
      set_vec(vecs[0]);
      wait_load();
      v9      = vecs[0];
      v9.m0   = 4'd9;
      v9.s[0] = 7'h6F;
      for (int i = 0; i < FRAME; i++) begin
         step();
         expect_pos("midframe_hold", i, vecs[0]);
         if (i == P + 3) min0 = 4'd9;
      end
      for (int i = 0; i < P; i++) begin
         step();
         expect_pos("midframe_next", i, v9);
      end

      // Asynchronous reset at slot 2, prescale 5.
      set_vec(vecs[0]);
      wait_load();
      for (int i = 0; i <= 2 * P + 5; i++) step();
      check("pre_reset_lit", 4'b0100, 7'h5B, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("async_clear", 4'b0000, 7'h00, 1'b0);
      step();
      check("held_in_reset", 4'b0000, 7'h00, 1'b0);
      #3 rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < P; i++) begin
         step();
         expect_pos("after_reset", i, zv);
      end

      // Random BCD frames: one-hot enables with exact on-time per slot.
      wait_load();
      for (int f = 0; f < 10; f++) begin
         min0  = 4'($urandom_range(0, 9));
         min1  = 4'($urandom_range(0, 9));
         hour0 = 4'($urandom_range(0, 9));
         hour1 = 4'($urandom_range(1, 9));
         colon = 1'($urandom_range(0, 1));
         for (int s = 0; s < 4; s++) cnt[s] = 0;
         for (int i = 0; i < FRAME; i++) begin
            step();
            ea = 4'b0001 << (i / P);
            tests++;
            if (!$onehot0(an) || (an != 4'b0000 && an != ea)) begin
               fails++;
               $display("FAIL onehot cyc=%0d: got an=%b, expected zero or %b", cyc, an, ea);
            end
            if (an == ea) cnt[i / P]++;
         end
         for (int s = 0; s < 4; s++) begin
            tests++;
            if (cnt[s] != P - D) begin
               fails++;
               $display("FAIL on_time frame=%0d slot=%0d: got %0d cycles, expected %0d",
                        f, s, cnt[s], P - D);
            end
         end
         if (f < 9) begin
            // next frame's inputs are sampled at the edge just taken
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
